// File: rtl/booth_mac_seq.sv
// booth_mac_seq
//   Operand sequencer + accumulator wrapped around a 4-bit sequential Booth
//   multiplier. Signed operand pairs are queued in a small FIFO. Each pair is
//   issued to the multiplier with a one-cycle start pulse. After STEPS
//   iteration cycles the 8-bit product is added into a 12-bit signed group
//   sum. A pair tagged `last` releases the sum on a valid/ready port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand pair handshake (in_a, in_b, in_last)
//   mul_start                one-cycle start pulse to the multiplier
//   mul_mcd, mul_multi       operands, held from START through CAPTURE
//   mul_prod                 signed product returned by the multiplier
//   acc_valid/acc_ready      group sum handshake (acc_sum, acc_ovf)
//   fifo_count               current FIFO occupancy
module booth_mac_seq #(
  parameter int DEPTH = 4,
  parameter int STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic        in_last,
  output logic        mul_start,
  output logic [3:0]  mul_mcd,
  output logic [3:0]  mul_multi,
  input  logic [7:0]  mul_prod,
  output logic        acc_valid,
  input  logic        acc_ready,
  output logic [11:0] acc_sum,
  output logic        acc_ovf,
  output logic [2:0]  fifo_count
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C   = 4'(DEPTH);
  localparam logic [3:0] LAST_WAIT = 4'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CAPTURE, S_EMIT
  } state_t;

  state_t state, state_nxt;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;
  logic          push, pop;

  logic [3:0]    op_a, op_b;
  logic          op_last;
  logic [3:0]    wcnt;

  logic [11:0]   prod_ext, sum_nxt;
  logic          ovf_step;

  // in_ready looks at occupancy only, so a full FIFO refuses a push even
  // in a cycle where it also pops.
  assign in_ready  = count < DEPTH_C;
  assign push      = in_valid && in_ready;
  assign pop       = (state == S_IDLE) && (count != 4'd0);

  // The port is 3 bits wide; a full 8-deep FIFO reads back as 7.
  assign fifo_count = (count > 4'd7) ? 3'd7 : count[2:0];

  assign mul_start = (state == S_START);
  assign acc_valid = (state == S_EMIT);
  assign mul_mcd   = op_a;
  assign mul_multi = op_b;

  assign prod_ext  = {{4{mul_prod[7]}}, mul_prod};
  assign sum_nxt   = acc_sum + prod_ext;
  // Signed overflow: addends agree in sign, result disagrees.
  assign ovf_step  = (acc_sum[11] == prod_ext[11]) && (sum_nxt[11] != acc_sum[11]);

  // FIFO storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= 4'd0;
      op_a    <= 4'd0;
      op_b    <= 4'd0;
      op_last <= 1'b0;
      wcnt    <= 4'd0;
      acc_sum <= 12'd0;
      acc_ovf <= 1'b0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                  <= rd_ptr + 1'b1;
        {op_a, op_b, op_last}   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase

      if (state == S_START)     wcnt <= 4'd0;
      else if (state == S_WAIT) wcnt <= wcnt + 4'd1;

      if (state == S_CAPTURE) begin
        acc_sum <= sum_nxt;
        acc_ovf <= acc_ovf | ovf_step;
      end else if (state == S_EMIT && acc_ready) begin
        acc_sum <= 12'd0;
        acc_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pop) state_nxt = S_START;
      S_START:   state_nxt = S_WAIT;
      S_WAIT:    if (wcnt == LAST_WAIT) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = op_last ? S_EMIT : S_IDLE;
      S_EMIT:    if (acc_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Self-checking bench for booth_mac_seq with a behavioural multiplier stub
// and a high-level group-sum reference model.
module tb_booth_mac_seq;
  localparam int DEPTH = 4;
  localparam int STEPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_a = 4'd0;
  logic [3:0]  in_b = 4'd0;
  logic        in_last = 1'b0;
  logic        mul_start;
  logic [3:0]  mul_mcd, mul_multi;
  logic [7:0]  mul_prod;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic [11:0] acc_sum;
  logic        acc_ovf;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mac_seq #(.DEPTH(DEPTH), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_start(mul_start), .mul_mcd(mul_mcd), .mul_multi(mul_multi),
    .mul_prod(mul_prod),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_sum(acc_sum), .acc_ovf(acc_ovf),
    .fifo_count(fifo_count)
  );

  // Multiplier stub: product valid from STEPS cycles after the start pulse,
  // junk before that so an early capture shows up.
  int sc = 0;
  logic signed [7:0] sa, sb;
  always @(posedge clk) begin
    if (rst)                   sc <= 0;
    else if (mul_start)        sc <= 1;
    else if (sc > 0 && sc < 100) sc <= sc + 1;
  end
  assign sa = {{4{mul_mcd[3]}}, mul_mcd};
  assign sb = {{4{mul_multi[3]}}, mul_multi};
  assign mul_prod = (sc >= STEPS) ? sa * sb : 8'h5a;

  // Monitor: samples the cycle ending at each rising edge.
  logic [11:0] got_sum[$];
  logic        got_ovf[$];
  logic [7:0]  issued[$];
  logic [8:0]  pushed[$];
  logic [11:0] exp_sum[$];
  logic        exp_ovf[$];

  int start_cnt = 0, full_seen = 0, over_cnt = 0, rdy_err = 0;
  int stab_err = 0, drop_err = 0, op_err = 0;
  logic        prev_rst = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0, prev_ovf = 1'b0;
  logic [11:0] prev_sum = 12'd0;
  logic [3:0]  prev_mcd = 4'd0, prev_multi = 4'd0;

  always @(posedge clk) begin
    prev_rst   <= rst;
    prev_valid <= acc_valid;
    prev_ready <= acc_ready;
    prev_sum   <= acc_sum;
    prev_ovf   <= acc_ovf;
    prev_mcd   <= mul_mcd;
    prev_multi <= mul_multi;
    if (!rst) begin
      if (acc_valid && acc_ready) begin
        got_sum.push_back(acc_sum);
        got_ovf.push_back(acc_ovf);
      end
      if (mul_start) begin
        start_cnt <= start_cnt + 1;
        issued.push_back({mul_mcd, mul_multi});
      end
      if (32'(fifo_count) == DEPTH && !in_ready) full_seen <= full_seen + 1;
      if (32'(fifo_count) > DEPTH) over_cnt <= over_cnt + 1;
      if (in_ready !== (32'(fifo_count) < DEPTH)) rdy_err <= rdy_err + 1;
      if (!prev_rst && prev_valid && !prev_ready) begin
        if (!acc_valid) drop_err <= drop_err + 1;
        else if (acc_sum !== prev_sum || acc_ovf !== prev_ovf) stab_err <= stab_err + 1;
      end
      if (!prev_rst && !mul_start && (mul_mcd !== prev_mcd || mul_multi !== prev_multi))
        op_err <= op_err + 1;
    end
  end

  // Reference: plain integer group sums with 12-bit signed wrap.
  function automatic void build_exp(input int from);
    int w, a, b;
    bit ovf;
    exp_sum.delete();
    exp_ovf.delete();
    w = 0;
    ovf = 0;
    for (int i = from; i < pushed.size(); i++) begin
      a = $signed(pushed[i][8:5]);
      b = $signed(pushed[i][4:1]);
      w = w + a * b;
      if (w > 2047)       begin w = w - 4096; ovf = 1; end
      else if (w < -2048) begin w = w + 4096; ovf = 1; end
      if (pushed[i][0]) begin
        exp_sum.push_back(12'(w));
        exp_ovf.push_back(ovf);
        w = 0;
        ovf = 0;
      end
    end
  endfunction

  // Offer one pair starting at the current falling edge; returns on the
  // falling edge after it is accepted.
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout in_ready=%0b want 1", in_ready);
    end else begin
      pushed.push_back({a, b, l});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, output bit ok);
    int guard;
    guard = 0;
    while (got_sum.size() < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    ok = (got_sum.size() >= target);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; acc_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (mul_start !== 1'b0 || acc_valid !== 1'b0) begin bad++; $display("FAIL reset_ctl start=%0b valid=%0b want 0 0", mul_start, acc_valid); end
    total++; if (acc_sum !== 12'd0 || acc_ovf !== 1'b0) begin bad++; $display("FAIL reset_acc sum=%0h ovf=%0b want 0 0", acc_sum, acc_ovf); end
    total++; if (mul_mcd !== 4'd0 || mul_multi !== 4'd0) begin bad++; $display("FAIL reset_ops mcd=%0h multi=%0h want 0 0", mul_mcd, mul_multi); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [9:0]  sv, vv;
    logic [11:0] s8, s9;
    logic        o8;
    sv = '0; vv = '0; s8 = '0; s9 = '1; o8 = 1'b1;
    acc_ready = 1'b1;
    push(4'd3, 4'd5, 1'b1);   // returns in cycle 1
    for (int c = 1; c <= 9; c++) begin
      sv[c] = mul_start;
      vv[c] = acc_valid;
      if (c == 8) begin s8 = acc_sum; o8 = acc_ovf; end
      if (c == 9) s9 = acc_sum;
      if (c < 9) @(negedge clk);
    end
    total++; if (sv !== 10'b0000000100) begin bad++; $display("FAIL single_start_cycles got=%b want=%b", sv, 10'b0000000100); end
    total++; if (vv !== 10'b0100000000) begin bad++; $display("FAIL single_valid_cycles got=%b want=%b", vv, 10'b0100000000); end
    total++; if (s8 !== 12'd15 || o8 !== 1'b0) begin bad++; $display("FAIL single_sum got=%0d/%0b want=15/0", s8, o8); end
    total++; if (s9 !== 12'd0) begin bad++; $display("FAIL single_cleared got=%0d want=0", s9); end
  endtask

  task automatic test_signed_group;
    int pb, gb;
    bit ok;
    pb = pushed.size(); gb = got_sum.size();
    acc_ready = 1'b1;
    push(4'(-8), 4'(-8), 1'b0);
    push(4'd7, 4'(-1), 1'b0);
    push(4'd2, 4'd3, 1'b1);
    wait_results(gb + 1, ok);
    repeat (20) @(negedge clk);
    build_exp(pb);
    total++; if (!ok || got_sum.size() != gb + 1) begin bad++; $display("FAIL group_count got=%0d want=1", got_sum.size() - gb); end
    if (ok) begin
      total++; if (got_sum[gb] !== exp_sum[0] || got_ovf[gb] !== exp_ovf[0]) begin bad++; $display("FAIL group_sum got=%0h/%0b want=%0h/%0b", got_sum[gb], got_ovf[gb], exp_sum[0], exp_ovf[0]); end
    end
  endtask

  task automatic test_fifo_full;
    int pb, gb, ib, f0, ov0, r0;
    bit ok;
    pb = pushed.size(); gb = got_sum.size(); ib = issued.size();
    f0 = full_seen; ov0 = over_cnt; r0 = rdy_err;
    acc_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(4'($urandom), 4'($urandom), i == 5);
    wait_results(gb + 1, ok);
    build_exp(pb);
    total++; if (full_seen == f0) begin bad++; $display("FAIL full_not_ready got=%0d want>0", full_seen - f0); end
    total++; if (over_cnt != ov0 || rdy_err != r0) begin bad++; $display("FAIL full_count over=%0d rdyerr=%0d want 0 0", over_cnt - ov0, rdy_err - r0); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (issued.size() <= ib + i || issued[ib + i] !== pushed[pb + i][8:1]) begin
        bad++; $display("FAIL full_order idx=%0d got=%0h want=%0h", i, (issued.size() > ib + i) ? issued[ib + i] : 8'h00, pushed[pb + i][8:1]);
      end
    end
    total++;
    if (!ok || got_sum[gb] !== exp_sum[0] || got_ovf[gb] !== exp_ovf[0]) begin
      bad++; $display("FAIL full_sum got=%0h want=%0h", ok ? got_sum[gb] : 12'h000, exp_sum[0]);
    end
  endtask

  task automatic test_overflow;
    int pb, gb;
    bit ok;
    pb = pushed.size(); gb = got_sum.size();
    acc_ready = 1'b1;
    for (int i = 0; i < 33; i++) push(4'(-8), 4'(-8), i == 32);
    push(4'd1, 4'd1, 1'b1);
    wait_results(gb + 2, ok);
    build_exp(pb);
    total++; if (!ok) begin bad++; $display("FAIL ovf_results got=%0d want=2", got_sum.size() - gb); end
    if (ok) begin
      total++; if (got_sum[gb] !== 12'h840 || got_ovf[gb] !== 1'b1) begin bad++; $display("FAIL ovf_sum got=%0h/%0b want=840/1", got_sum[gb], got_ovf[gb]); end
      total++; if (got_sum[gb] !== exp_sum[0] || got_ovf[gb] !== exp_ovf[0]) begin bad++; $display("FAIL ovf_model got=%0h want=%0h", got_sum[gb], exp_sum[0]); end
      total++; if (got_sum[gb+1] !== 12'd1 || got_ovf[gb+1] !== 1'b0) begin bad++; $display("FAIL ovf_next got=%0h/%0b want=1/0", got_sum[gb+1], got_ovf[gb+1]); end
    end
  endtask

  task automatic test_backpressure;
    int pb, gb, s0, st0, guard;
    logic [11:0] hs;
    logic ho;
    bit ok;
    pb = pushed.size(); gb = got_sum.size();
    acc_ready = 1'b0;
    push(4'($urandom), 4'($urandom), 1'b1);
    guard = 0;
    while (!acc_valid && guard < 60) begin @(negedge clk); guard++; end
    total++; if (!acc_valid) begin bad++; $display("FAIL bp_valid_timeout got=%0b want=1", acc_valid); end
    hs = acc_sum; ho = acc_ovf;
    s0 = start_cnt; st0 = stab_err + drop_err;
    for (int i = 0; i < 4; i++) push(4'($urandom), 4'($urandom), i == 3);
    repeat (6) @(negedge clk);
    build_exp(pb);
    total++; if (acc_valid !== 1'b1 || hs !== exp_sum[0] || acc_sum !== hs || acc_ovf !== ho) begin bad++; $display("FAIL bp_hold sum=%0h want=%0h valid=%0b", acc_sum, exp_sum[0], acc_valid); end
    total++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_fill count=%0d rdy=%0b want 4 0", fifo_count, in_ready); end
    total++; if (start_cnt != s0 || stab_err + drop_err != st0) begin bad++; $display("FAIL bp_nopop starts=%0d stab=%0d want 0 0", start_cnt - s0, stab_err + drop_err - st0); end
    acc_ready = 1'b1;
    @(negedge clk);
    total++; if (acc_valid !== 1'b0 || mul_start !== 1'b0 || acc_sum !== 12'd0) begin bad++; $display("FAIL bp_release valid=%0b start=%0b sum=%0h want 0 0 0", acc_valid, mul_start, acc_sum); end
    @(negedge clk);
    total++; if (mul_start !== 1'b1 || fifo_count !== 3'd3) begin bad++; $display("FAIL bp_restart start=%0b count=%0d want 1 3", mul_start, fifo_count); end
    wait_results(gb + 2, ok);
    total++;
    if (!ok || got_sum[gb+1] !== exp_sum[1] || got_ovf[gb+1] !== exp_ovf[1]) begin
      bad++; $display("FAIL bp_second got=%0h want=%0h", ok ? got_sum[gb+1] : 12'h000, exp_sum[1]);
    end
  endtask

  task automatic test_reset_mid;
    int pb, gb, s0, guard;
    bit ok;
    acc_ready = 1'b1;
    s0 = start_cnt;
    push(4'd3, 4'd3, 1'b0);
    push(4'd1, 4'd2, 1'b0);
    push(4'd4, 4'd1, 1'b0);
    push(4'd2, 4'd2, 1'b1);
    guard = 0;
    while (start_cnt < s0 + 2 && guard < 60) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    total++; if (fifo_count !== 3'd2 || acc_sum !== 12'd9) begin bad++; $display("FAIL rmid_pre count=%0d sum=%0d want 2 9", fifo_count, acc_sum); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_fifo count=%0d rdy=%0b want 0 1", fifo_count, in_ready); end
    total++; if (mul_start || acc_valid || acc_ovf || acc_sum !== 12'd0 || mul_mcd !== 4'd0 || mul_multi !== 4'd0) begin bad++; $display("FAIL rmid_outputs start=%0b valid=%0b sum=%0h", mul_start, acc_valid, acc_sum); end
    rst = 1'b0;
    s0 = start_cnt; gb = got_sum.size();
    repeat (10) @(negedge clk);
    total++; if (start_cnt != s0 || got_sum.size() != gb) begin bad++; $display("FAIL rmid_quiet starts=%0d results=%0d want 0 0", start_cnt - s0, got_sum.size() - gb); end
    pb = pushed.size();
    push(4'd2, 4'(-3), 1'b1);
    wait_results(gb + 1, ok);
    build_exp(pb);
    total++;
    if (!ok || got_sum[gb] !== 12'hffa || got_sum[gb] !== exp_sum[0] || got_ovf[gb] !== 1'b0) begin
      bad++; $display("FAIL rmid_after got=%0h want=ffa", ok ? got_sum[gb] : 12'h000);
    end
  endtask

  task automatic test_random;
    int pb, gb, ib, e0;
    bit ok, done;
    pb = pushed.size(); gb = got_sum.size(); ib = issued.size();
    e0 = stab_err + drop_err + op_err + rdy_err + over_cnt;
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(2) == 0) @(negedge clk);
          push(4'($urandom), 4'($urandom), (i == 39) || ($urandom_range(3) == 0));
        end
        done = 1;
      end
      begin
        while (!done) begin
          acc_ready = 1'($urandom);
          @(negedge clk);
        end
      end
    join
    acc_ready = 1'b1;
    build_exp(pb);
    wait_results(gb + exp_sum.size(), ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_sum.size() - gb, exp_sum.size()); end
    if (ok) begin
      for (int i = 0; i < exp_sum.size(); i++) begin
        total++;
        if (got_sum[gb+i] !== exp_sum[i] || got_ovf[gb+i] !== exp_ovf[i]) begin
          bad++; $display("FAIL rand_sum idx=%0d got=%0h/%0b want=%0h/%0b", i, got_sum[gb+i], got_ovf[gb+i], exp_sum[i], exp_ovf[i]);
        end
      end
    end
    total++;
    ok = (issued.size() == ib + 40);
    for (int i = 0; i < 40 && ok; i++) if (issued[ib+i] !== pushed[pb+i][8:1]) ok = 0;
    if (!ok) begin bad++; $display("FAIL rand_order issued=%0d want=40 in order", issued.size() - ib); end
    total++; if (stab_err + drop_err + op_err + rdy_err + over_cnt != e0) begin bad++; $display("FAIL rand_protocol errs=%0d want=0", stab_err + drop_err + op_err + rdy_err + over_cnt - e0); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_signed_group();
    test_fifo_full();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
